// File: rtl/game_phase_sequencer.sv
// -----------------------------------------------------------------------------
// game_phase_sequencer
//
// Top-level phase sequencer for the symbol-counting game. It owns the 1 s
// timebase, the length of every phase, the answer judgement and the level
// progression. It drives one-hot phase flags into the 7-segment display
// controller, plus the page index used by the post-phase segment mux.
//
// Phase order: IDLE -> PRE -> GAME -> ANSWER -> POST -> (PRE | LOSE | VICTORY)
// LOSE and VICTORY are sticky until start, which returns to IDLE.
//
// Ports:
//   Clk100M    in   system clock
//   Rst        in   asynchronous reset, active-high
//   start      in   single-cycle start/restart pulse (debounced)
//   submit     in   single-cycle answer submit pulse (debounced)
//   userCount  in   [7:0] player's entered count
//   gameCount  in   [7:0] true symbol count of the current round
//   pre, game, answer, post, lose, victory
//              out  one-hot phase flags, all low in IDLE
//   postPage   out  [1:0] 0 = P1 count, 1 = game count, 2 = difference, 3 = result
//   level      out  [3:0] levels passed so far, saturates at MAX_LEVEL
//   secTick    out  one-cycle pulse once per second
//
// Optional feature macro: ANSWER_TIMEOUT_EN
//   Defined   : ANSWER gives up after ANSWER_SEC seconds without a submit and
//               moves to POST with the round judged as failed.
//   Undefined : ANSWER waits for submit indefinitely.
// -----------------------------------------------------------------------------
module game_phase_sequencer #(
  parameter int CLK_HZ     = 100000000,
  parameter int PRE_SEC    = 3,
  parameter int GAME_SEC   = 10,
  parameter int PAGE_SEC   = 2,
  parameter int TOL        = 0,
  parameter int MAX_LEVEL  = 5,
  parameter int ANSWER_SEC = 15
) (
  input  logic       Clk100M,
  input  logic       Rst,
  input  logic       start,
  input  logic       submit,
  input  logic [7:0] userCount,
  input  logic [7:0] gameCount,
  output logic       pre,
  output logic       game,
  output logic       answer,
  output logic       post,
  output logic       lose,
  output logic       victory,
  output logic [1:0] postPage,
  output logic [3:0] level,
  output logic       secTick
);

  // Divider width covers 0..CLK_HZ-1; second counter covers the longest phase.
  localparam int DIV_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SEC_MAX_A = (PRE_SEC > GAME_SEC) ? PRE_SEC : GAME_SEC;
  localparam int SEC_MAX_B = (PAGE_SEC > ANSWER_SEC) ? PAGE_SEC : ANSWER_SEC;
  localparam int SEC_MAX   = (SEC_MAX_A > SEC_MAX_B) ? SEC_MAX_A : SEC_MAX_B;
  localparam int SEC_W     = $clog2(SEC_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_HZ - 1);
  localparam logic [SEC_W-1:0] PRE_LAST  = SEC_W'(PRE_SEC - 1);
  localparam logic [SEC_W-1:0] GAME_LAST = SEC_W'(GAME_SEC - 1);
  localparam logic [SEC_W-1:0] PAGE_LAST = SEC_W'(PAGE_SEC - 1);
  localparam logic [3:0]       MAX_LVL   = 4'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_GAME,
    S_ANSWER,
    S_POST,
    S_LOSE,
    S_VICTORY
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [1:0]       page_q, page_d;
  logic [3:0]       level_q, level_d;
  logic             pass_q, pass_d;
  logic             sec_tick_q;
  logic             pre_q, game_q, answer_q, post_q, lose_q, victory_q;
  logic             pre_d, game_d, answer_d, post_d, lose_d, victory_d;

  logic             tick;
  logic [8:0]       diff;
  logic [8:0]       abs_diff;
  logic             answer_ok;
  logic [3:0]       level_inc;

  assign tick = (div_q == DIV_LAST);

  // Subtract at 9 bits so a large gap in either direction cannot wrap.
  assign diff      = {1'b0, userCount} - {1'b0, gameCount};
  assign abs_diff  = diff[8] ? (9'd0 - diff) : diff;
  assign answer_ok = (int'({23'd0, abs_diff}) <= TOL);

  assign level_inc = (level_q < MAX_LVL) ? level_q + 4'd1 : level_q;

  // ---------------------------------------------------------------------------
  // State register and all registered outputs.
  // NOTE: every register here is written with <= so all flops update from the
  // same pre-edge values; a blocking = would let later lines see new values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk100M or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      sec_q      <= '0;
      page_q     <= 2'd0;
      level_q    <= 4'd0;
      pass_q     <= 1'b0;
      sec_tick_q <= 1'b0;
      pre_q      <= 1'b0;
      game_q     <= 1'b0;
      answer_q   <= 1'b0;
      post_q     <= 1'b0;
      lose_q     <= 1'b0;
      victory_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sec_q      <= sec_d;
      page_q     <= page_d;
      level_q    <= level_d;
      pass_q     <= pass_d;
      sec_tick_q <= tick;
      pre_q      <= pre_d;
      game_q     <= game_d;
      answer_q   <= answer_d;
      post_q     <= post_d;
      lose_q     <= lose_d;
      victory_q  <= victory_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, including the timebase and the round bookkeeping.
  // NOTE: every variable gets a default before the case statement, so no path
  // leaves one unassigned and no latch is inferred.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + DIV_W'(1);
    sec_d   = tick ? sec_q + SEC_W'(1) : sec_q;
    page_d  = page_q;
    level_d = level_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_PRE;
      end
      S_PRE: begin
        if (tick && sec_q == PRE_LAST) state_d = S_GAME;
      end
      S_GAME: begin
        if (tick && sec_q == GAME_LAST) state_d = S_ANSWER;
      end
      S_ANSWER: begin
        // submit takes priority over a simultaneous start (start is ignored).
        if (submit) begin
          pass_d  = answer_ok;
          state_d = S_POST;
        end
`ifdef ANSWER_TIMEOUT_EN
        else if (tick && sec_q == SEC_W'(ANSWER_SEC - 1)) begin
          pass_d  = 1'b0;
          state_d = S_POST;
        end
`endif
      end
      S_POST: begin
        if (tick && sec_q == PAGE_LAST) begin
          sec_d = '0;
          if (page_q == 2'd3) begin
            if (pass_q) begin
              level_d = level_inc;
              state_d = (level_inc == MAX_LVL) ? S_VICTORY : S_PRE;
            end else begin
              state_d = S_LOSE;
            end
          end else begin
            page_d = page_q + 2'd1;
          end
        end
      end
      S_LOSE, S_VICTORY: begin
        if (start) begin
          level_d = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Restart the timebase on every phase entry so each phase is an exact
    // whole number of seconds; the page index only lives inside POST.
    if (state_d != state_q) begin
      div_d  = '0;
      sec_d  = '0;
      page_d = 2'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode: flags follow the next state so they are registered
  // together with it and change on the same edge as the transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    pre_d     = (state_d == S_PRE);
    game_d    = (state_d == S_GAME);
    answer_d  = (state_d == S_ANSWER);
    post_d    = (state_d == S_POST);
    lose_d    = (state_d == S_LOSE);
    victory_d = (state_d == S_VICTORY);
  end

  assign pre      = pre_q;
  assign game     = game_q;
  assign answer   = answer_q;
  assign post     = post_q;
  assign lose     = lose_q;
  assign victory  = victory_q;
  assign postPage = page_q;
  assign level    = level_q;
  assign secTick  = sec_tick_q;

endmodule
